// File: rtl/dequant_stream_ctrl_pkg.sv
// Shared types and constants for the dequantizer stream controller.
//   deq_ctrl_state_e : controller FSM states
//   DEQ_PIPE_LAT     : dequantizer datapath latency (valid_in -> valid_out)
//   DEQ_ISSUE_LAT    : read issue -> deq_valid_out latency (buffer read + datapath)
package dequant_stream_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} deq_ctrl_state_e;

  localparam int DEQ_PIPE_LAT  = 2;
  localparam int DEQ_ISSUE_LAT = DEQ_PIPE_LAT + 1;

  // A job with no elements or an out-of-range channel count is rejected.
  function automatic logic cfg_invalid(input int unsigned num_elems,
                                       input int unsigned num_ch,
                                       input int unsigned max_ch);
    return (num_elems == 0) || (num_ch == 0) || (num_ch > max_ch);
  endfunction

endpackage

// File: rtl/dequant_stream_ctrl_credit_counter.sv
// credit_counter: saturating up/down credit counter, reusable by any stream
// controller that gates issue on downstream slots.
//   clk, rst  : clock, async active-high reset (count -> MAX)
//   i_inc     : one slot returned (ignored when already at MAX)
//   i_dec     : one slot consumed (ignored when already 0)
//   o_count   : current credit count
//   o_avail   : count != 0
// Simultaneous inc and dec leave the count unchanged.
module credit_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_avail
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= W'(MAX);
    end else begin
      case ({i_inc, i_dec})
        2'b10:   if (r_count != W'(MAX)) r_count <= r_count + W'(1);
        2'b01:   if (r_count != '0)      r_count <= r_count - W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_avail = (r_count != '0);

endmodule

// File: rtl/dequant_stream_ctrl.sv
// dequant_stream_ctrl: streams an INT8 tensor from buffer memory through the
// dequantizer. Generates read addresses, channel IDs (channel innermost) and
// valid strobes, gates issue on downstream credits and signals job completion.
//   clk, rst                 : clock, async active-high reset
//   start, abort             : job control pulses
//   cfg_base_addr/num_elems/num_ch : job config, latched on accepted start
//   busy, done, err          : status (err sticky until next accepted start)
//   rd_en, rd_addr, rd_data  : buffer read port (data 1 cycle after rd_en)
//   deq_*                    : dequantizer drive + valid_out completion monitor
//   credit_return            : downstream freed one slot
// Optional macro DEQ_STREAM_PERF_EN adds perf_stall_cycles / perf_job_cycles.
module dequant_stream_ctrl
  import dequant_stream_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int CNT_WIDTH    = 20,
  parameter int NUM_CHANNELS = 16,
  parameter int CREDITS      = 8,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [ADDR_WIDTH-1:0]           cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]            cfg_num_elems,
  input  logic [$clog2(NUM_CHANNELS):0]   cfg_num_ch,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            rd_en,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            deq_enable,
  output logic                            deq_valid_in,
  output logic [DATA_WIDTH-1:0]           deq_data_in,
  output logic [$clog2(NUM_CHANNELS)-1:0] deq_channel_id,
  input  logic                            deq_valid_out,
  input  logic                            credit_return
`ifdef DEQ_STREAM_PERF_EN
  ,
  output logic [31:0]                     perf_stall_cycles,
  output logic [31:0]                     perf_job_cycles
`endif
);

  localparam int CH_W  = $clog2(NUM_CHANNELS);
  localparam int NCH_W = CH_W + 1;
  localparam int CR_W  = $clog2(CREDITS + 1);

  deq_ctrl_state_e       r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [NCH_W-1:0]      r_nch;
  logic [CNT_WIDTH-1:0]  r_issued;
  logic [CNT_WIDTH-1:0]  r_completed;
  logic [CH_W-1:0]       r_ch_cnt;
  logic                  r_err;
  logic                  r_aborting;
  logic [1:0]            r_flush;
  logic                  r_vld;
  logic [CH_W-1:0]       r_ch_d;

  logic [CR_W-1:0]       w_credits;
  logic                  w_credit_avail;
  logic                  w_issue;
  logic                  w_active;
  logic                  w_cfg_bad;

  assign w_active  = (r_state == RUN) || (r_state == DRAIN);
  assign w_cfg_bad = cfg_invalid(32'(cfg_num_elems), 32'(cfg_num_ch), NUM_CHANNELS);

  // abort gates issue combinationally so rd_en drops in the abort cycle itself
  assign w_issue = (r_state == RUN) && !r_aborting && !abort &&
                   w_credit_avail && (r_issued < r_num);

  credit_counter #(.MAX(CREDITS), .W(CR_W)) u_credits (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (credit_return),
    .i_dec   (w_issue),
    .o_count (w_credits),
    .o_avail (w_credit_avail)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_num       <= '0;
      r_nch       <= '0;
      r_issued    <= '0;
      r_completed <= '0;
      r_ch_cnt    <= '0;
      r_err       <= 1'b0;
      r_aborting  <= 1'b0;
      r_flush     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base      <= cfg_base_addr;
            r_num       <= cfg_num_elems;
            r_nch       <= cfg_num_ch;
            r_issued    <= '0;
            r_completed <= '0;
            r_ch_cnt    <= '0;
            r_aborting  <= 1'b0;
            r_err       <= w_cfg_bad;
            r_state     <= w_cfg_bad ? DONE : RUN;
          end
        end
        RUN, DRAIN: begin
          if (r_aborting) begin
            // in-flight reads drain through the datapath, uncounted
            if (r_flush == 2'd1) r_state <= DONE;
            else                 r_flush <= r_flush - 2'd1;
          end else if (abort) begin
            r_aborting <= 1'b1;
            r_flush    <= 2'(DEQ_ISSUE_LAT);
          end else begin
            if (w_issue) begin
              r_issued <= r_issued + CNT_WIDTH'(1);
              if ({1'b0, r_ch_cnt} == r_nch - NCH_W'(1)) r_ch_cnt <= '0;
              else                                        r_ch_cnt <= r_ch_cnt + CH_W'(1);
              if (r_issued + CNT_WIDTH'(1) == r_num) r_state <= DRAIN;
            end
            if (deq_valid_out) begin
              r_completed <= r_completed + CNT_WIDTH'(1);
              if (r_state == DRAIN && (r_completed + CNT_WIDTH'(1) == r_num))
                r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_aborting <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // buffer read takes one cycle; valid and channel ride alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_ch_d <= '0;
    end else begin
      r_vld <= w_issue;
      if (w_issue) r_ch_d <= r_ch_cnt;
    end
  end

  assign busy           = (r_state != IDLE);
  assign done           = (r_state == DONE);
  assign err            = r_err;
  assign deq_enable     = busy;
  assign rd_en          = w_issue;
  assign rd_addr        = w_issue ? r_base + ADDR_WIDTH'(r_issued) : '0;
  assign deq_valid_in   = r_vld;
  assign deq_channel_id = r_vld ? r_ch_d : '0;
  assign deq_data_in    = r_vld ? rd_data : '0;

`ifdef DEQ_STREAM_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_job_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_job_cycles   <= '0;
    end else if (r_state == IDLE && start) begin
      r_stall_cycles <= '0;
      r_job_cycles   <= '0;
    end else begin
      if (w_active) r_job_cycles <= r_job_cycles + 32'd1;
      if (r_state == RUN && !w_credit_avail) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign perf_stall_cycles = r_stall_cycles;
  assign perf_job_cycles   = r_job_cycles;
`endif

endmodule
